// File: rtl/aibcr3_preclkbuf_seq.sv
`default_nettype none
// ============================================================================
// Module  : aibcr3_preclkbuf_seq
// Brief   : Pre-clock-buffer sequencer. Powers the buffer, opens the clock gate
//           after a settle dwell, closes it glitch-free on disable or source change.
// Revision: 1.0  initial release
// ============================================================================
module aibcr3_preclkbuf_seq #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_req,
  input  logic             src_sel,
  input  logic [CNT_W-1:0] cfg_settle,
  input  logic [CNT_W-1:0] cfg_drain,
  output logic             pwr_en,
  output logic             mux_sel,
  output logic             gate_en,
  output logic             en_ack,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWRUP   = 3'd1,
    ST_ON      = 3'd2,
    ST_GATEOFF = 3'd3,
    ST_SWITCH  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_pwr,   w_pwr_nxt;
  logic             r_mux,   w_mux_nxt;
  logic             r_gate,  w_gate_nxt;
  logic             r_ack,   w_ack_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_pwr   <= 1'b0;
      r_mux   <= 1'b0;
      r_gate  <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pwr   <= w_pwr_nxt;
      r_mux   <= w_mux_nxt;
      r_gate  <= w_gate_nxt;
      r_ack   <= w_ack_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Outputs are computed for the state being entered so every output is a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pwr_nxt   = r_pwr;
    w_mux_nxt   = r_mux;
    w_gate_nxt  = r_gate;
    w_ack_nxt   = r_ack;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_OFF: begin
        w_mux_nxt = src_sel;
        if (en_req) begin
          w_state_nxt = ST_PWRUP;
          w_cnt_nxt   = cfg_settle;
          w_pwr_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_PWRUP: begin
        // A dropped request beats settle completion so the gate never opens
        // for a path that is no longer wanted.
        if (!en_req) begin
          w_state_nxt = ST_GATEOFF;
          w_cnt_nxt   = cfg_drain;
        end else if (w_cnt_zero) begin
          w_state_nxt = ST_ON;
          w_gate_nxt  = 1'b1;
          w_ack_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      ST_ON: begin
        if (!en_req || (src_sel != r_mux)) begin
          w_state_nxt = ST_GATEOFF;
          w_cnt_nxt   = cfg_drain;
          w_gate_nxt  = 1'b0;
          w_ack_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_GATEOFF: begin
        if (w_cnt_zero) begin
          if (!en_req) begin
            w_state_nxt = ST_OFF;
            w_pwr_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_SWITCH;
            w_mux_nxt   = src_sel;
            w_cnt_nxt   = cfg_settle;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      ST_SWITCH: begin
        if (w_cnt_zero) begin
          if (en_req) begin
            w_state_nxt = ST_ON;
            w_gate_nxt  = 1'b1;
            w_ack_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_GATEOFF;
            w_cnt_nxt   = cfg_drain;
          end
        end else begin
          w_cnt_nxt = r_cnt - C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = '0;
        w_pwr_nxt   = 1'b0;
        w_gate_nxt  = 1'b0;
        w_ack_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign pwr_en  = r_pwr;
  assign mux_sel = r_mux;
  assign gate_en = r_gate;
  assign en_ack  = r_ack;
  assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aibcr3_preclkbuf_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_aibcr3_preclkbuf_seq
// Brief   : Directed scoreboard bench for the pre-clock-buffer sequencer.
// Revision: 1.0  initial release
// ============================================================================
module tb_aibcr3_preclkbuf_seq;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en_req;
  logic             src_sel;
  logic [CNT_W-1:0] cfg_settle;
  logic [CNT_W-1:0] cfg_drain;
  logic             pwr_en, mux_sel, gate_en, en_ack, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected output vector per cycle: {pwr_en, gate_en, en_ack, busy, mux_sel}
  logic [4:0] exp_q[$];
  logic       prev_mux = 1'b0;

  aibcr3_preclkbuf_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en_req(en_req), .src_sel(src_sel),
    .cfg_settle(cfg_settle), .cfg_drain(cfg_drain),
    .pwr_en(pwr_en), .mux_sel(mux_sel), .gate_en(gate_en),
    .en_ack(en_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {pwr_en, gate_en, en_ack, busy, mux_sel};
  endfunction

  task automatic expect_n(input int n, input logic [4:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Advance one clock per queued entry, comparing away from the active edge.
  task automatic drain_q(input string tag);
    logic [4:0] e;
    logic [4:0] o;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = obs();
      n_cmp++;
      assert (o === e) else begin
        n_bad++;
        $error("FAIL %s: observed=%b expected=%b", tag, o, e);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic [4:0] e);
    logic [4:0] o;
    o = obs();
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, o, e);
    end
  endtask

  // The gate must be closed in any cycle where the mux select moves.
  always @(negedge clk) begin
    if (mux_sel !== prev_mux) begin
      n_cmp++;
      assert (gate_en === 1'b0) else begin
        n_bad++;
        $error("FAIL mux_change_gate: observed gate_en=%b expected=0", gate_en);
      end
    end
    prev_mux <= mux_sel;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en_req = 1'b0; src_sel = 1'b0; cfg_settle = '0; cfg_drain = '0;
    #2;
    check_now("reset", 5'b00000);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_now("post_reset", 5'b00000);

    // Enable with settle=3: 4 busy cycles then on.
    cfg_settle = 4'd3; en_req = 1'b1;
    expect_n(4, 5'b10010); expect_n(1, 5'b11100);
    drain_q("enable_s3");

    // Disable with drain=2.
    cfg_drain = 4'd2; en_req = 1'b0;
    expect_n(3, 5'b10010); expect_n(1, 5'b00000);
    drain_q("disable_d2");

    // Re-enable, then source switch with drain=1, settle=2.
    cfg_settle = 4'd2; en_req = 1'b1;
    expect_n(3, 5'b10010); expect_n(1, 5'b11100);
    drain_q("enable_s2");
    cfg_drain = 4'd1; src_sel = 1'b1;
    expect_n(2, 5'b10010); expect_n(3, 5'b10011); expect_n(1, 5'b11101);
    drain_q("switch_d1_s2");

    // Disable with drain=1, mux stays at 1.
    en_req = 1'b0;
    expect_n(2, 5'b10011); expect_n(1, 5'b00001);
    drain_q("disable_d1");

    // Request dropped during a long power-up: gate must stay closed.
    cfg_settle = 4'd7; en_req = 1'b1;
    expect_n(3, 5'b10011);
    drain_q("pwrup_s7");
    cfg_drain = 4'd2; en_req = 1'b0;
    expect_n(3, 5'b10011); expect_n(1, 5'b00001);
    drain_q("pwrup_abort");

    // Zero dwells: enable, switch, disable.
    cfg_settle = 4'd0; cfg_drain = 4'd0; src_sel = 1'b0; en_req = 1'b1;
    expect_n(1, 5'b10010); expect_n(1, 5'b11100);
    drain_q("enable_s0");
    src_sel = 1'b1;
    expect_n(1, 5'b10010); expect_n(1, 5'b10011); expect_n(1, 5'b11101);
    drain_q("switch_zero");
    en_req = 1'b0;
    expect_n(1, 5'b10011); expect_n(1, 5'b00001);
    drain_q("disable_d0");

    // Maximum settle: 16-cycle dwell without counter wrap.
    cfg_settle = 4'd15; en_req = 1'b1;
    expect_n(16, 5'b10011); expect_n(1, 5'b11101);
    drain_q("enable_s15");

    // Asynchronous reset while on.
    rst = 1'b1;
    #1;
    check_now("rst_in_on", 5'b00000);
    #1;
    rst = 1'b0;
    cfg_settle = 4'd1;
    expect_n(2, 5'b10011); expect_n(1, 5'b11101);
    drain_q("restart_after_on_rst");

    // Asynchronous reset while switching.
    cfg_drain = 4'd0; cfg_settle = 4'd3; src_sel = 1'b0;
    expect_n(1, 5'b10011); expect_n(2, 5'b10010);
    drain_q("into_switch");
    rst = 1'b1;
    #1;
    check_now("rst_in_switch", 5'b00000);
    #1;
    rst = 1'b0;
    cfg_settle = 4'd0;
    expect_n(1, 5'b10010); expect_n(1, 5'b11100);
    drain_q("restart_after_switch_rst");

    en_req = 1'b0;
    expect_n(1, 5'b10010); expect_n(1, 5'b00000);
    drain_q("final_disable");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
